// File: rtl/aes128_round_key_store.sv
// AES-128 round key store: sequences aes128_key_expansion through rounds 0..9,
// captures K0..K10 into a register file and serves 1-cycle-latency random reads
// (including reverse order for the inverse cipher).
module aes128_round_key_store #(
  parameter int unsigned KEY_W = 128,
  parameter int unsigned NR    = 10
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             key_load,
  input  logic             key_clear,
  input  logic [KEY_W-1:0] cipher_key,
  input  logic [KEY_W-1:0] exp_round_key,
  output logic             exp_rkey_en,
  output logic [3:0]       exp_round_num,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_err,
  output logic             busy,
  output logic             keys_ready
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned NSLOT = NR + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXPAND  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READY   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_keys_ready;
  logic               w_ready_nxt;
  logic               r_exp_en;
  logic [CNT_W-1:0]   r_exp_num;

  logic               w_wr_en;
  logic [CNT_W-1:0]   w_wr_idx;
  logic [KEY_W-1:0]   w_wr_data;
  logic               w_clear;

  logic [KEY_W-1:0]   r_slot [NSLOT];

  logic               w_rd_ok;
  logic               r_rd_valid;
  logic [KEY_W-1:0]   r_rd_key;
  logic               r_rd_err;

  // State register
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, round counter and slot write decode; clear beats load
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_ready_nxt = r_keys_ready;
    w_wr_en     = 1'b0;
    w_wr_idx    = '0;
    w_wr_data   = '0;
    w_clear     = 1'b0;
    if (key_clear) begin
      w_clear     = 1'b1;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_ready_nxt = 1'b0;
    end else if (key_load) begin
      w_wr_en     = 1'b1;
      w_wr_idx    = '0;
      w_wr_data   = cipher_key;
      w_state_nxt = ST_EXPAND;
      w_cnt_nxt   = '0;
      w_busy_nxt  = 1'b1;
      w_ready_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_EXPAND: begin
          if (r_cnt != '0) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_cnt;
            w_wr_data = exp_round_key;
          end
          if (r_cnt == CNT_W'(NR - 1)) begin
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          w_wr_en     = 1'b1;
          w_wr_idx    = CNT_W'(NR);
          w_wr_data   = exp_round_key;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_READY;
        end
        default: begin
        end
      endcase
    end
  end

  // Control registers; expansion handshake is registered from the next state
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_keys_ready <= 1'b0;
      r_exp_en     <= 1'b0;
      r_exp_num    <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_busy       <= w_busy_nxt;
      r_keys_ready <= w_ready_nxt;
      r_exp_en     <= (w_state_nxt == ST_EXPAND);
      r_exp_num    <= (w_state_nxt == ST_EXPAND) ? w_cnt_nxt : '0;
    end
  end

  // Round key register file; not reset, only zeroized by key_clear
  always_ff @(posedge clk_sys) begin
    if (w_clear) begin
      for (int i = 0; i < int'(NSLOT); i++) begin
        r_slot[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_slot[w_wr_idx] <= w_wr_data;
    end
  end

  assign w_rd_ok = rd_en && r_keys_ready && (rd_idx <= CNT_W'(NR));

  // Registered read port; sees keys_ready before any same-edge load
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_rd_valid <= 1'b0;
      r_rd_key   <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_key   <= w_rd_ok ? r_slot[rd_idx] : '0;
      r_rd_err   <= rd_en && !w_rd_ok;
    end
  end

  assign exp_rkey_en   = r_exp_en;
  assign exp_round_num = r_exp_num;
  assign rd_valid      = r_rd_valid;
  assign rd_key        = r_rd_key;
  assign rd_err        = r_rd_err;
  assign busy          = r_busy;
  assign keys_ready    = r_keys_ready;

endmodule

// File: tb/tb_aes128_round_key_store.sv
// Testbench for aes128_round_key_store with a behavioural key-expansion block
// and a word-level FIPS-197 key schedule reference model.
module tb_aes128_round_key_store;

  logic         clk_sys = 1'b0;
  logic         rst_sys;
  logic         key_load;
  logic         key_clear;
  logic [127:0] cipher_key;
  logic [127:0] exp_round_key;
  logic         exp_rkey_en;
  logic [3:0]   exp_round_num;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         rd_err;
  logic         busy;
  logic         keys_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox [256];
  logic [127:0] m_slot [11];
  logic         m_ready;
  logic [127:0] exp_rk = '0;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes128_round_key_store #(.KEY_W(128), .NR(10)) dut (
    .clk_sys       (clk_sys),
    .rst_sys       (rst_sys),
    .key_load      (key_load),
    .key_clear     (key_clear),
    .cipher_key    (cipher_key),
    .exp_round_key (exp_round_key),
    .exp_rkey_en   (exp_rkey_en),
    .exp_round_num (exp_round_num),
    .rd_en         (rd_en),
    .rd_idx        (rd_idx),
    .rd_valid      (rd_valid),
    .rd_key        (rd_key),
    .rd_err        (rd_err),
    .busy          (busy),
    .keys_ready    (keys_ready)
  );

  always #5 clk_sys = ~clk_sys;

  // GF(2^8) arithmetic and S-box derived from the field inverse
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    if (x != 8'h00) begin
      v = 8'h01;
      for (int i = 0; i < 254; i++) v = gmul(v, x);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 0; i < r; i++) c = gmul(c, 8'h02);
    return c;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] step_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(int'(r)), 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Stand-in for aes128_key_expansion: registered next round key per rkey_en
  always @(posedge clk_sys) begin
    if (exp_rkey_en) begin
      exp_rk <= step_key((exp_round_num == 4'd0) ? cipher_key : exp_rk, exp_round_num);
    end
  end
  assign exp_round_key = exp_rk;

  // Reference key schedule over 44 words
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i/4 - 1), 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) m_slot[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_load(input logic [127:0] key);
    cipher_key = key;
    key_load   = 1'b1;
    tick();
    key_load   = 1'b0;
  endtask

  task automatic finish_load(input logic [127:0] key);
    int n;
    n = 0;
    while (!keys_ready && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!keys_ready) begin
      n_err++;
      $display("FAIL load_timeout: keys_ready=%b after %0d cycles, want 1", keys_ready, n);
    end
    model_expand(key);
    m_ready = 1'b1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_sys = 1'b1; key_load = 1'b0; key_clear = 1'b0; cipher_key = '0;
    rd_en = 1'b0; rd_idx = '0; m_ready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({exp_rkey_en, exp_round_num, rd_valid, rd_err, busy, keys_ready} !== 9'd0 || rd_key !== '0) begin
      n_err++;
      $display("FAIL reset_outs: en=%b num=%0d v=%b err=%b busy=%b rdy=%b key=%h, want all 0",
               exp_rkey_en, exp_round_num, rd_valid, rd_err, busy, keys_ready, rd_key);
    end
    rst_sys = 1'b0;
    rd_en = 1'b1; rd_idx = 4'd0;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({rd_valid, rd_err} !== 2'b11 || rd_key !== '0) begin
      n_err++;
      $display("FAIL read_before_ready: v=%b err=%b key=%h, want v=1 err=1 key=0", rd_valid, rd_err, rd_key);
    end
  endtask

  task automatic test_basic_expansion();
    start_load(KEY_A);
    for (int r = 0; r < 10; r++) begin
      n_cmp++;
      if ({exp_rkey_en, exp_round_num, busy, keys_ready} !== {1'b1, 4'(r), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL expand_step[%0d]: en=%b num=%0d busy=%b rdy=%b, want en=1 num=%0d busy=1 rdy=0",
                 r, exp_rkey_en, exp_round_num, busy, keys_ready, r);
      end
      tick();
    end
    n_cmp++;
    if ({exp_rkey_en, exp_round_num, busy, keys_ready} !== 7'b0_0000_10) begin
      n_err++;
      $display("FAIL capture_cycle: en=%b num=%0d busy=%b rdy=%b, want en=0 num=0 busy=1 rdy=0",
               exp_rkey_en, exp_round_num, busy, keys_ready);
    end
    tick();
    n_cmp++;
    if ({exp_rkey_en, busy, keys_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL ready_rise: en=%b busy=%b rdy=%b, want en=0 busy=0 rdy=1", exp_rkey_en, busy, keys_ready);
    end
    model_expand(KEY_A);
    m_ready = 1'b1;
  endtask

  task automatic test_reverse_read();
    logic [127:0] want;
    for (int i = 10; i >= 0; i--) begin
      rd_en = 1'b1; rd_idx = 4'(i);
      tick();
      want = m_slot[i];
      if (i == 10) want = A_K10;
      if (i == 1)  want = A_K1;
      if (i == 0)  want = KEY_A;
      n_cmp++;
      if ({rd_valid, rd_err} !== 2'b10 || rd_key !== want || rd_key !== m_slot[i]) begin
        n_err++;
        $display("FAIL rev_read[%0d]: v=%b err=%b key=%h, want v=1 err=0 key=%h", i, rd_valid, rd_err, rd_key, want);
      end
    end
    rd_en = 1'b0;
    tick();
    n_cmp++;
    if ({rd_valid, rd_err} !== 2'b00 || rd_key !== '0) begin
      n_err++;
      $display("FAIL rd_idle: v=%b err=%b key=%h, want all 0", rd_valid, rd_err, rd_key);
    end
  endtask

  task automatic test_illegal_reads();
    logic [3:0]   bad [2];
    logic [127:0] k;
    int           idx;
    bad[0] = 4'd11; bad[1] = 4'd15;
    for (int j = 0; j < 2; j++) begin
      rd_en = 1'b1; rd_idx = bad[j];
      tick();
      rd_en = 1'b0;
      n_cmp++;
      if ({rd_valid, rd_err} !== 2'b11 || rd_key !== '0) begin
        n_err++;
        $display("FAIL illegal_idx[%0d]: v=%b err=%b key=%h, want v=1 err=1 key=0", bad[j], rd_valid, rd_err, rd_key);
      end
    end
    k = rand_key();
    idx = int'($urandom_range(10, 0));
    cipher_key = k; key_load = 1'b1; rd_en = 1'b1; rd_idx = 4'(idx);
    tick();
    key_load = 1'b0;
    n_cmp++;
    if ({rd_valid, rd_err} !== 2'b10 || rd_key !== m_slot[idx]) begin
      n_err++;
      $display("FAIL read_with_load[%0d]: v=%b err=%b key=%h, want v=1 err=0 key=%h", idx, rd_valid, rd_err, rd_key, m_slot[idx]);
    end
    m_ready = 1'b0;
    rd_idx = 4'($urandom_range(10, 0));
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({rd_valid, rd_err} !== 2'b11 || rd_key !== '0) begin
      n_err++;
      $display("FAIL read_while_busy: v=%b err=%b key=%h, want v=1 err=1 key=0", rd_valid, rd_err, rd_key);
    end
    finish_load(k);
  endtask

  task automatic test_restart();
    start_load(KEY_A);
    repeat (4) tick();
    n_cmp++;
    if (exp_round_num !== 4'd4 || !busy) begin
      n_err++;
      $display("FAIL restart_pre: num=%0d busy=%b, want num=4 busy=1", exp_round_num, busy);
    end
    m_ready = 1'b0;
    start_load(KEY_C);
    for (int r = 0; r < 10; r++) begin
      n_cmp++;
      if ({exp_rkey_en, exp_round_num} !== {1'b1, 4'(r)}) begin
        n_err++;
        $display("FAIL restart_step[%0d]: en=%b num=%0d, want en=1 num=%0d", r, exp_rkey_en, exp_round_num, r);
      end
      tick();
    end
    finish_load(KEY_C);
    rd_en = 1'b1; rd_idx = 4'd10;
    tick();
    n_cmp++;
    if (rd_key !== C_K10 || rd_err !== 1'b0) begin
      n_err++;
      $display("FAIL restart_k10: key=%h err=%b, want key=%h err=0", rd_key, rd_err, C_K10);
    end
    rd_idx = 4'd0;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if (rd_key !== KEY_C) begin
      n_err++;
      $display("FAIL restart_k0: key=%h, want %h", rd_key, KEY_C);
    end
  endtask

  task automatic test_key_clear();
    logic [127:0] k1, k2, k3;
    k1 = rand_key(); k2 = rand_key(); k3 = rand_key();
    start_load(k1);
    repeat (3) tick();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    m_ready = 1'b0;
    n_cmp++;
    if ({exp_rkey_en, exp_round_num, busy, keys_ready} !== 7'd0) begin
      n_err++;
      $display("FAIL clear_abort: en=%b num=%0d busy=%b rdy=%b, want all 0", exp_rkey_en, exp_round_num, busy, keys_ready);
    end
    repeat (3) tick();
    rd_en = 1'b1; rd_idx = 4'd0;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({exp_rkey_en, busy, rd_err} !== 3'b001 || rd_key !== '0) begin
      n_err++;
      $display("FAIL clear_idle: en=%b busy=%b err=%b key=%h, want en=0 busy=0 err=1 key=0", exp_rkey_en, busy, rd_err, rd_key);
    end
    cipher_key = k2; key_load = 1'b1; key_clear = 1'b1;
    tick();
    key_load = 1'b0; key_clear = 1'b0;
    tick();
    n_cmp++;
    if ({exp_rkey_en, busy, keys_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL clear_vs_load: en=%b busy=%b rdy=%b, want all 0", exp_rkey_en, busy, keys_ready);
    end
    start_load(k3);
    finish_load(k3);
    rd_en = 1'b1; rd_idx = 4'd0;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if (rd_key !== k3 || rd_err !== 1'b0) begin
      n_err++;
      $display("FAIL clear_reload_k0: key=%h err=%b, want key=%h err=0", rd_key, rd_err, k3);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    start_load(rand_key());
    repeat (6) tick();
    m_ready = 1'b0;
    rd_en = 1'b1; rd_idx = 4'd0;
    rst_sys = 1'b1;
    tick();
    rst_sys = 1'b0; rd_en = 1'b0;
    n_cmp++;
    if ({exp_rkey_en, exp_round_num, rd_valid, rd_err, busy, keys_ready} !== 9'd0 || rd_key !== '0) begin
      n_err++;
      $display("FAIL reset_mid: en=%b num=%0d v=%b err=%b busy=%b rdy=%b key=%h, want all 0",
               exp_rkey_en, exp_round_num, rd_valid, rd_err, busy, keys_ready, rd_key);
    end
    k = rand_key();
    start_load(k);
    finish_load(k);
  endtask

  task automatic test_back_to_back_random();
    logic         ev, ee;
    logic [127:0] ek;
    int           idx;
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < 30; c++) begin
        rd_en  = 1'($urandom_range(1, 0));
        idx    = int'($urandom_range(15, 0));
        rd_idx = 4'(idx);
        ev = rd_en;
        ee = rd_en && !(m_ready && idx <= 10);
        ek = (rd_en && m_ready && idx <= 10) ? m_slot[idx] : '0;
        tick();
        n_cmp++;
        if (rd_valid !== ev || rd_err !== ee || rd_key !== ek) begin
          n_err++;
          $display("FAIL rand_read[%0d.%0d idx=%0d]: v=%b err=%b key=%h, want v=%b err=%b key=%h",
                   it, c, idx, rd_valid, rd_err, rd_key, ev, ee, ek);
        end
      end
      rd_en = 1'b0;
      begin
        logic [127:0] k;
        k = rand_key();
        m_ready = 1'b0;
        start_load(k);
        finish_load(k);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
    test_reset();
    test_basic_expansion();
    test_reverse_read();
    test_illegal_reads();
    test_restart();
    test_key_clear();
    test_reset_mid();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
